fwd_pass: RTL

FWD_PASS -- requirements
Module: fwd_pass

---
 rtl/dt_pkg.sv | 42 ++++
 rtl/dt_min4.sv | 24 ++
 rtl/fwd_pass.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dt_pkg.sv
// dt_pkg: shared definitions for the distance-transform passes.
//   IMG_W / ADDR_W / PIX_W / PIX_MAX : image geometry and pixel format
//   COORD_W                           : width of a row or column index
//   SCAN_FIRST / SCAN_LAST            : interior scan range (border excluded)
//   fwd_state_t                       : forward-pass FSM states
//   pix_addr()                        : row/col -> linear RAM address
//   pix_sat_inc()                     : +1 saturating at PIX_MAX
package dt_pkg;

    localparam int unsigned IMG_W   = 128;
    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned PIX_MAX = 255;
    localparam int unsigned COORD_W = ADDR_W / 2;

    localparam logic [COORD_W-1:0] SCAN_FIRST = COORD_W'(1);
    localparam logic [COORD_W-1:0] SCAN_LAST  = COORD_W'(IMG_W - 2);

    typedef enum logic [2:0] {
        IDLE,
        RD_C,
        CHK,
        RD_N,
        RD_NE,
        CMP,
        WR,
        DONE
    } fwd_state_t;

    // IMG_W is a power of two, so row*IMG_W+col is a plain concatenation.
    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [COORD_W-1:0] row,
        input logic [COORD_W-1:0] col
    );
        return {row, col};
    endfunction

    function automatic logic [PIX_W-1:0] pix_sat_inc(input logic [PIX_W-1:0] v);
        return (v == PIX_W'(PIX_MAX)) ? v : v + PIX_W'(1);
    endfunction

endpackage

// File: rtl/dt_min4.sv
// dt_min4: combinational unsigned minimum of four pixels.
//   a, b, c, d : pixel inputs
//   y          : smallest of the four
// Shared by the forward and backward distance-transform passes.
module dt_min4
    import dt_pkg::*;
(
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] c,
    input  logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] y
);

    logic [PIX_W-1:0] min_ab;
    logic [PIX_W-1:0] min_cd;

    always_comb begin
        min_ab = (a < b) ? a : b;
        min_cd = (c < d) ? c : d;
        y      = (min_ab < min_cd) ? min_ab : min_cd;
    end

endmodule

// File: rtl/fwd_pass.sv
// fwd_pass: raster-order forward distance-transform pass over the interior
// (rows/cols 1..126) of a 128x128 image held in the res RAM.
//   clk      : clock, rising edge
//   reset    : synchronous, active-low
//   fwd_en   : start request (level), sampled only in IDLE and DONE
//   res_addr : RAM address, row*128+col
//   res_rd   : read strobe; res_di valid the following cycle
//   res_di   : RAM read data
//   res_wr   : write strobe; res_do written to res_addr
//   res_do   : write data
//   fwd_done : pass finished; held until fwd_en drops
// Each object pixel becomes min(NW, N, NE, W) + 1 (saturating); background
// pixels are left untouched. W is kept in a register, the row above is read.
module fwd_pass
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              fwd_en,
    output logic [ADDR_W-1:0] res_addr,
    output logic              res_rd,
    input  logic [PIX_W-1:0]  res_di,
    output logic              res_wr,
    output logic [PIX_W-1:0]  res_do,
    output logic              fwd_done
);

    fwd_state_t         state;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [PIX_W-1:0]   w_pix;
    logic [PIX_W-1:0]   nw_pix;
    logic [PIX_W-1:0]   n_pix;

    logic               last_col;
    logic               last_pix;
    logic [COORD_W-1:0] nxt_row;
    logic [COORD_W-1:0] nxt_col;
    logic [COORD_W-1:0] row_up;
    logic               advance;
    logic [PIX_W-1:0]   min_val;
    logic [PIX_W-1:0]   result;

    // NE arrives on res_di during CMP, so it feeds the minimum directly.
    dt_min4 u_min (
        .a (nw_pix),
        .b (n_pix),
        .c (res_di),
        .d (w_pix),
        .y (min_val)
    );

    always_comb begin
        last_col = (col == SCAN_LAST);
        last_pix = last_col && (row == SCAN_LAST);
        nxt_col  = last_col ? SCAN_FIRST : col + COORD_W'(1);
        nxt_row  = last_col ? row + COORD_W'(1) : row;
        row_up   = row - COORD_W'(1);
        advance  = ((state == CHK) && (res_di == '0)) || (state == WR);
        result   = pix_sat_inc(min_val);
    end

    // Outputs are registered: each strobe/address is set on the edge that
    // enters the state in which it is presented. The NW read shown during
    // CHK is therefore issued before C is known; for a background pixel it
    // is simply ignored, which keeps background pixels at two cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            row      <= SCAN_FIRST;
            col      <= SCAN_FIRST;
            w_pix    <= '0;
            nw_pix   <= '0;
            n_pix    <= '0;
            res_addr <= '0;
            res_rd   <= 1'b0;
            res_wr   <= 1'b0;
            res_do   <= '0;
            fwd_done <= 1'b0;
        end else begin
            res_rd   <= 1'b0;
            res_wr   <= 1'b0;
            res_addr <= '0;
            res_do   <= '0;

            case (state)
                IDLE: begin
                    fwd_done <= 1'b0;
                    if (fwd_en) begin
                        row      <= SCAN_FIRST;
                        col      <= SCAN_FIRST;
                        w_pix    <= '0;
                        res_rd   <= 1'b1;
                        res_addr <= pix_addr(SCAN_FIRST, SCAN_FIRST);
                        state    <= RD_C;
                    end
                end

                RD_C: begin
                    res_rd   <= 1'b1;
                    res_addr <= pix_addr(row_up, col - COORD_W'(1));
                    state    <= CHK;
                end

                CHK: begin
                    if (res_di != '0) begin
                        res_rd   <= 1'b1;
                        res_addr <= pix_addr(row_up, col);
                        state    <= RD_N;
                    end
                end

                RD_N: begin
                    nw_pix   <= res_di;
                    res_rd   <= 1'b1;
                    res_addr <= pix_addr(row_up, col + COORD_W'(1));
                    state    <= RD_NE;
                end

                RD_NE: begin
                    n_pix <= res_di;
                    state <= CMP;
                end

                CMP: begin
                    res_wr   <= 1'b1;
                    res_addr <= pix_addr(row, col);
                    res_do   <= result;
                    state    <= WR;
                end

                WR: begin
                    // pixel advance handled below, shared with CHK
                end

                DONE: begin
                    if (fwd_en) begin
                        fwd_done <= 1'b1;
                    end else begin
                        fwd_done <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase

            // Shared pixel advance for a background CHK and for WR. During
            // WR, res_do still holds the freshly written result.
            if (advance) begin
                w_pix <= (last_col || (state == CHK)) ? '0 : res_do;
                if (last_pix) begin
                    fwd_done <= 1'b1;
                    state    <= DONE;
                end else begin
                    row      <= nxt_row;
                    col      <= nxt_col;
                    res_rd   <= 1'b1;
                    res_addr <= pix_addr(nxt_row, nxt_col);
                    state    <= RD_C;
                end
            end
        end
    end

endmodule
